// File: rtl/shift_sub_div_rca_if.sv
// Start/busy/done bus for the restoring shift-subtract divider.
// The requester uses the master modport and the divider uses the slave modport.
interface shift_sub_div_rca_if #(
  parameter int WIDTH = 256
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  logic [2*WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]     remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/shift_sub_div_rca.sv
// Sequential restoring divider: a 2*WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
// Results are loaded on the edge that enters FIN, so they are valid for the whole done cycle.
module shift_sub_div_rca #(
  parameter int WIDTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  shift_sub_div_rca_if.slave bus
);
  localparam int QW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(QW);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t            state, state_nxt;
  logic [QW-1:0]     q_reg;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  dvsr;
  logic [CNT_W-1:0]  cnt;
  logic [QW-1:0]     quotient_r;
  logic [WIDTH-1:0]  remainder_r;
  logic              dbz_r;

  logic [WIDTH:0]    trial;
  logic [WIDTH-1:0]  diff;
  logic [WIDTH-1:0]  rem_step;
  logic              bit_step;
  logic              last_step;
  logic              zero_dvsr;

  // The compare is WIDTH+1 bits wide so the bit shifted out of rem is never lost;
  // whenever the difference is taken it is below the divisor and fits in WIDTH bits.
  always_comb begin
    trial     = {rem, q_reg[QW-1]};
    bit_step  = (trial >= {1'b0, dvsr});
    diff      = trial[WIDTH-1:0] - dvsr;
    rem_step  = bit_step ? diff : trial[WIDTH-1:0];
    last_step = (cnt == CNT_W'(QW - 1));
    zero_dvsr = (bus.divisor == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = zero_dvsr ? FIN : CALC;
      CALC:    if (last_step) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state == CALC);
    bus.done        = (state == FIN);
    bus.quotient    = quotient_r;
    bus.remainder   = remainder_r;
    bus.div_by_zero = dbz_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg       <= '0;
      rem         <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && !zero_dvsr) begin
            q_reg <= bus.dividend;
            dvsr  <= bus.divisor;
            rem   <= '0;
            cnt   <= '0;
          end else if (bus.start) begin
            // Divide by zero skips CALC and reports straight away.
            quotient_r  <= '1;
            remainder_r <= bus.dividend[WIDTH-1:0];
            dbz_r       <= 1'b1;
          end
        end
        CALC: begin
          q_reg <= {q_reg[QW-2:0], bit_step};
          rem   <= rem_step;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            quotient_r  <= {q_reg[QW-2:0], bit_step};
            remainder_r <= rem_step;
            dbz_r       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
